// File: rtl/accel_mailbox_pkg.sv
// accel_mailbox_pkg: shared definitions for the processor <-> accelerator mailbox.
// Holds the FSM state encoding (also exposed in the status word), the
// status and command bit positions, and the register-file geometry.
package accel_mailbox_pkg;

  localparam int NUM_REGS   = 8;
  localparam int NUM_PARAMS = 6;
  localparam int REG_W      = 32;
  localparam int OP_W       = 4;

  // Command word (regs_from_proc[0]) field positions
  localparam int CMD_START  = 0;
  localparam int CMD_IRQ_EN = 1;
  localparam int CMD_OP_LSB = 4;

  // Status word (regs_to_proc[0]) field positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_TIMEOUT   = 3;
  localparam int STAT_STATE_LSB = 4;

  // Encoding is software-visible in status bits [7:4]
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_REQ  = 4'd1,
    ST_BUSY = 4'd2,
    ST_DONE = 4'd3
  } mbox_state_e;

endpackage

// File: rtl/mailbox_timeout_ctr.sv
// mailbox_timeout_ctr: saturating busy-cycle counter with timeout compare.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear to zero (wins over en)
//   en        - count one cycle (holds at all-ones)
//   cnt       - current count
//   at_limit  - count equals TIMEOUT_CYCLES-1
module mailbox_timeout_ctr
  import accel_mailbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/accel_mailbox.sv
// accel_mailbox: register mailbox that lets a processor launch one
// accelerator job at a time and read back status, results and cycle count.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   regs_from_proc   - processor command word [0] and parameters [1..6]
//   regs_to_proc     - status word [0], results [1..6], busy-cycle count [7]
//   ext_irq          - one-cycle completion pulse (when irq_en was latched)
//   acc_req/acc_ack  - request handshake to the accelerator
//   acc_op/acc_param - latched opcode and parameters for the in-flight job
//   acc_done/acc_err - completion strobe and error flag
//   acc_result       - results, valid with acc_done
module accel_mailbox
  import accel_mailbox_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] regs_from_proc [0:NUM_REGS-1],
  output logic [REG_W-1:0] regs_to_proc   [0:NUM_REGS-1],
  output logic             ext_irq,
  output logic             acc_req,
  input  logic             acc_ack,
  output logic [OP_W-1:0]  acc_op,
  output logic [REG_W-1:0] acc_param      [0:NUM_PARAMS-1],
  input  logic             acc_done,
  input  logic             acc_err,
  input  logic [REG_W-1:0] acc_result     [0:NUM_PARAMS-1]
);

  mbox_state_e      state_d, state_q;
  logic             done_d, done_q, err_d, err_q, tmo_d, tmo_q;
  logic             irq_en_d, irq_en_q, ext_irq_d, ext_irq_q, acc_req_d, acc_req_q;
  logic             start_prev_q, armed_q;
  logic [OP_W-1:0]  op_d, op_q;
  logic [REG_W-1:0] params_d  [0:NUM_PARAMS-1];
  logic [REG_W-1:0] params_q  [0:NUM_PARAMS-1];
  logic [REG_W-1:0] results_d [0:NUM_PARAMS-1];
  logic [REG_W-1:0] results_q [0:NUM_PARAMS-1];
  logic             cnt_clr, cnt_en, at_limit;
  logic [CNT_W-1:0] cnt;
  logic             start_bit, start_rise;
  logic             unused_bits;

  assign start_bit = regs_from_proc[0][CMD_START];
  // armed_q stays low for the first cycle after reset so a start bit that is
  // already high at release is seen as "previous" rather than as a fresh edge.
  assign start_rise = armed_q && start_bit && !start_prev_q;
  assign unused_bits = ^{regs_from_proc[0][REG_W-1:CMD_OP_LSB+OP_W],
                         regs_from_proc[0][CMD_OP_LSB-1:CMD_IRQ_EN+1],
                         regs_from_proc[NUM_REGS-1]};

  mailbox_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt),
    .at_limit(at_limit)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    irq_en_d  = irq_en_q;
    op_d      = op_q;
    params_d  = params_q;
    results_d = results_q;
    ext_irq_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          op_d     = regs_from_proc[0][CMD_OP_LSB +: OP_W];
          irq_en_d = regs_from_proc[0][CMD_IRQ_EN];
          for (int i = 0; i < NUM_PARAMS; i++) params_d[i] = regs_from_proc[i+1];
          done_d   = 1'b0;
          err_d    = 1'b0;
          tmo_d    = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (acc_ack) begin
          // Accept and complete in one cycle when done arrives with the ack
          if (acc_done) begin
            results_d = acc_result;
            err_d     = acc_err;
            done_d    = 1'b1;
            ext_irq_d = irq_en_q;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_en = 1'b1;
        if (acc_done) begin
          results_d = acc_result;
          err_d     = acc_err;
          done_d    = 1'b1;
          ext_irq_d = irq_en_q;
          state_d   = ST_DONE;
        end else if (at_limit) begin
          tmo_d     = 1'b1;
          err_d     = 1'b1;
          done_d    = 1'b1;
          ext_irq_d = irq_en_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start_bit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    acc_req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      ext_irq_q    <= 1'b0;
      acc_req_q    <= 1'b0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      op_q         <= '0;
      params_q     <= '{default: '0};
      results_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      irq_en_q     <= irq_en_d;
      ext_irq_q    <= ext_irq_d;
      acc_req_q    <= acc_req_d;
      start_prev_q <= start_bit;
      armed_q      <= 1'b1;
      op_q         <= op_d;
      params_q     <= params_d;
      results_q    <= results_d;
    end
  end

  always_comb begin
    regs_to_proc[0]                 = '0;
    regs_to_proc[0][STAT_BUSY]      = (state_q == ST_REQ) || (state_q == ST_BUSY);
    regs_to_proc[0][STAT_DONE]      = done_q;
    regs_to_proc[0][STAT_ERR]       = err_q;
    regs_to_proc[0][STAT_TIMEOUT]   = tmo_q;
    regs_to_proc[0][STAT_STATE_LSB +: 4] = state_q;
    for (int i = 0; i < NUM_PARAMS; i++) regs_to_proc[i+1] = results_q[i];
    regs_to_proc[NUM_REGS-1]        = REG_W'(cnt);
  end

  assign ext_irq   = ext_irq_q;
  assign acc_req   = acc_req_q;
  assign acc_op    = op_q;
  assign acc_param = params_q;

endmodule

// File: tb/tb_accel_mailbox.sv
// tb_accel_mailbox: randomized bench for accel_mailbox with a job-level
// reference model, per-cycle output comparison and directed scenarios.
module tb_accel_mailbox;
  import accel_mailbox_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] regs_from_proc [0:7];
  logic [31:0] regs_to_proc   [0:7];
  logic        ext_irq, acc_req, acc_ack, acc_done, acc_err;
  logic [3:0]  acc_op;
  logic [31:0] acc_param  [0:5];
  logic [31:0] acc_result [0:5];

  int checks = 0;
  int errors = 0;
  int irq_pulses = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  accel_mailbox #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .regs_from_proc(regs_from_proc),
    .regs_to_proc  (regs_to_proc),
    .ext_irq       (ext_irq),
    .acc_req       (acc_req),
    .acc_ack       (acc_ack),
    .acc_op        (acc_op),
    .acc_param     (acc_param),
    .acc_done      (acc_done),
    .acc_err       (acc_err),
    .acc_result    (acc_result)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (job level) ----------------
  int          m_state;   // 0 idle, 1 requesting, 2 running, 3 finished
  logic        m_done, m_err, m_to, m_irq, m_irqen, m_prev, m_armed;
  logic [3:0]  m_op;
  logic [31:0] m_param [0:5];
  logic [31:0] m_res   [0:5];
  longint      m_cnt;

  task automatic mreset();
    m_state = 0; m_done = 0; m_err = 0; m_to = 0; m_irq = 0; m_irqen = 0;
    m_prev = 0; m_armed = 0; m_op = 0; m_cnt = 0;
    for (int i = 0; i < 6; i++) begin m_param[i] = 0; m_res[i] = 0; end
  endtask

  task automatic finish_job(input bit timed_out);
    if (timed_out) begin
      m_to = 1; m_err = 1;
    end else begin
      for (int i = 0; i < 6; i++) m_res[i] = acc_result[i];
      m_err = acc_err;
    end
    m_done = 1;
    m_state = 3;
    m_irq = m_irqen;
  endtask

  task automatic mstep();
    logic st, rise;
    st = regs_from_proc[0][0];
    rise = m_armed && st && !m_prev;
    m_prev = st;
    m_armed = 1;
    m_irq = 0;
    case (m_state)
      0: if (rise) begin
           m_op = regs_from_proc[0][7:4];
           m_irqen = regs_from_proc[0][1];
           for (int i = 0; i < 6; i++) m_param[i] = regs_from_proc[i+1];
           m_done = 0; m_err = 0; m_to = 0; m_cnt = 0;
           m_state = 1;
         end
      1: if (acc_ack) begin
           if (acc_done) finish_job(0);
           else m_state = 2;
         end
      2: begin
           if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
           if (acc_done) finish_job(0);
           else if (m_cnt == TO) finish_job(1);
         end
      default: if (!st) m_state = 0;
    endcase
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) mreset();
      else mstep();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    logic busy;
    forever begin
      @(negedge clk);
      if (ext_irq === 1'b1) irq_pulses++;
      if (acc_req === 1'b1 && req_prev !== 1'b1) req_rises++;
      req_prev = acc_req;
      busy = (m_state == 1) || (m_state == 2);
      chk("status", regs_to_proc[0], {24'd0, m_state[3:0], m_to, m_err, m_done, busy});
      for (int i = 0; i < 6; i++) chk("result", regs_to_proc[i+1], m_res[i]);
      chk("count", regs_to_proc[7], m_cnt[31:0]);
      chk("acc_req", {31'd0, acc_req}, {31'd0, m_state == 1});
      chk("ext_irq", {31'd0, ext_irq}, {31'd0, m_irq});
      chk("acc_op", {28'd0, acc_op}, {28'd0, m_op});
      for (int i = 0; i < 6; i++) chk("acc_param", acc_param[i], m_param[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (acc_req !== 1'b1 && n < 50) begin cyc(1); n++; end
    checks++;
    if (acc_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: acc_req=%b required 1 within 50 cycles", nm, acc_req);
    end
  endtask

  task automatic scribble();
    for (int i = 1; i < 7; i++) regs_from_proc[i] = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int irq0, req0, mode, dly;
    logic [31:0] w;
    acc_ack = 0; acc_done = 0; acc_err = 0;
    for (int i = 0; i < 6; i++) acc_result[i] = 0;
    for (int i = 0; i < 8; i++) regs_from_proc[i] = 0;
    regs_from_proc[0] = 32'h1;           // start already high across reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", regs_to_proc[0], 32'h0);
    chk("rst_req", {31'd0, acc_req}, 32'h0);
    rst = 0;
    cyc(5);
    chk("start_high_at_release", {31'd0, acc_req}, 32'h0);
    chk("idle_status", regs_to_proc[0], 32'h0);
    regs_from_proc[0] = 32'h0;
    cyc(2);

    // Basic job: op 3, irq_en, ack 2 cycles after req, done 10 cycles after ack
    irq0 = irq_pulses;
    for (int i = 1; i < 7; i++) regs_from_proc[i] = 32'h100 + i;
    regs_from_proc[0] = 32'h32; cyc(1);
    regs_from_proc[0] = 32'h33;
    wait_req("basic_req");
    chk("basic_op", {28'd0, acc_op}, 32'h3);
    chk("basic_param1", acc_param[0], 32'h101);
    cyc(2);
    acc_ack = 1; cyc(1); acc_ack = 0;
    cyc(9);
    acc_done = 1;
    for (int i = 0; i < 6; i++) acc_result[i] = i + 1;
    cyc(1);
    acc_done = 0;
    cyc(3);
    chk("basic_status", regs_to_proc[0], 32'h32);
    chk("basic_res1", regs_to_proc[1], 32'd1);
    chk("basic_res6", regs_to_proc[6], 32'd6);
    chk("basic_count", regs_to_proc[7], 32'd10);
    chk("basic_irq_pulses", irq_pulses - irq0, 32'd1);

    // Held start: no retrigger; then clear and restart (also same-cycle ack+done)
    req0 = req_rises;
    cyc(20);
    chk("held_no_req", req_rises - req0, 32'd0);
    regs_from_proc[0] = 32'h32; cyc(2);
    chk("idle_keeps_done", regs_to_proc[0], 32'h02);
    chk("idle_keeps_res", regs_to_proc[1], 32'd1);
    regs_from_proc[0] = 32'h33;
    wait_req("restart_req");
    chk("restart_done_cleared", regs_to_proc[0], 32'h11);
    for (int i = 0; i < 6; i++) acc_result[i] = 32'hA0 + i;
    acc_ack = 1; acc_done = 1; cyc(1);
    acc_ack = 0; acc_done = 0;
    chk("same_cycle_status", regs_to_proc[0], 32'h32);
    chk("same_cycle_count", regs_to_proc[7], 32'd0);
    chk("same_cycle_res1", regs_to_proc[1], 32'hA0);
    regs_from_proc[0] = 32'h0; cyc(2);

    // Timeout: ack, never done
    irq0 = irq_pulses;
    regs_from_proc[0] = 32'h52; cyc(1);
    regs_from_proc[0] = 32'h53;
    wait_req("timeout_req");
    acc_ack = 1; cyc(1); acc_ack = 0;
    cyc(25);
    chk("timeout_status", regs_to_proc[0], 32'h3E);
    chk("timeout_count", regs_to_proc[7], 32'd16);
    chk("timeout_keeps_res", regs_to_proc[1], 32'hA0);
    chk("timeout_irq", irq_pulses - irq0, 32'd1);
    regs_from_proc[0] = 32'h0; cyc(2);

    // irq_en = 0 with error completion
    irq0 = irq_pulses;
    regs_from_proc[0] = 32'h70; cyc(1);
    regs_from_proc[0] = 32'h71;
    wait_req("noirq_req");
    acc_ack = 1; cyc(1); acc_ack = 0;
    cyc(3);
    acc_done = 1; acc_err = 1; cyc(1);
    acc_done = 0; acc_err = 0;
    cyc(3);
    chk("noirq_status", regs_to_proc[0], 32'h36);
    chk("noirq_count", regs_to_proc[7], 32'd4);
    chk("noirq_irq", irq_pulses - irq0, 32'd0);
    regs_from_proc[0] = 32'h0; cyc(2);

    // Reset in the middle of a running job
    regs_from_proc[0] = 32'h92; cyc(1);
    regs_from_proc[0] = 32'h93;
    wait_req("midrst_req");
    acc_ack = 1; cyc(1); acc_ack = 0;
    cyc(4);
    rst = 1;
    #1;
    for (int i = 0; i < 8; i++) chk("midrst_regs", regs_to_proc[i], 32'h0);
    chk("midrst_req", {31'd0, acc_req}, 32'h0);
    chk("midrst_irq", {31'd0, ext_irq}, 32'h0);
    chk("midrst_op", {28'd0, acc_op}, 32'h0);
    chk("midrst_param", acc_param[0], 32'h0);
    cyc(2);
    rst = 0;
    cyc(5);
    chk("midrst_no_restart", {31'd0, acc_req}, 32'h0);
    regs_from_proc[0] = 32'h0; cyc(2);

    // Randomized jobs
    for (int j = 0; j < 60; j++) begin
      scribble();
      w = $urandom; w[0] = 1'b0; regs_from_proc[0] = w;
      if ($urandom_range(0, 3) == 0) begin
        acc_done = 1; acc_err = 1;
        for (int i = 0; i < 6; i++) acc_result[i] = $urandom;
      end
      cyc(1);
      acc_done = 0; acc_err = 0;
      regs_from_proc[0][0] = 1'b1;
      wait_req("rand_req");
      repeat ($urandom_range(0, 3)) begin
        scribble();
        w = $urandom; w[0] = 1'b1; regs_from_proc[0] = w;
        cyc(1);
      end
      for (int i = 0; i < 6; i++) acc_result[i] = $urandom;
      acc_err = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        acc_ack = 1; acc_done = 1; cyc(1);
        acc_ack = 0; acc_done = 0;
      end else begin
        acc_ack = 1; cyc(1); acc_ack = 0;
        if (mode == 2) regs_from_proc[0][0] = 1'b0;
        scribble();
        dly = $urandom_range(0, 20);
        if (dly > 0) cyc(dly);
        acc_done = 1; cyc(1); acc_done = 0;
      end
      acc_err = 0;
      cyc($urandom_range(1, 4));
      regs_from_proc[0][0] = 1'b0;
      cyc(2);
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accel_mailbox.md
ACCEL_MAILBOX -- requirements
Module: accel_mailbox

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1048576: maximum cycles allowed in the BUSY state before the block aborts.
REQ-002 SHALL have parameter CNT_W, default 32: width of the busy-cycle counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port regs_from_proc, input, 32 bits x 8 (indices 0 to 7): the processor's accelerator-out registers.
REQ-006 SHALL have port regs_to_proc, output, 32 bits x 8 (indices 0 to 7): drives the processor's accelerator-in registers.
REQ-007 SHALL have port ext_irq, output, 1 bit: one-cycle completion pulse to the processor EXT input.
REQ-008 SHALL have port acc_req, output, 1 bit: request to the accelerator.
REQ-009 SHALL have port acc_ack, input, 1 bit: the accelerator accepts the request.
REQ-010 SHALL have port acc_op, output, 4 bits: opcode, taken from regs_from_proc[0][7:4].
REQ-011 SHALL have port acc_param, output, 32 bits x 6: parameters latched from regs_from_proc[1..6].
REQ-012 SHALL have port acc_done, input, 1 bit: one-cycle completion strobe from the accelerator.
REQ-013 SHALL have port acc_err, input, 1 bit: error flag, sampled together with acc_done.
REQ-014 SHALL have port acc_result, input, 32 bits x 6: results, valid while acc_done is high.

Function
REQ-015 SHALL define the command word as regs_from_proc[0]: bit0 start, bit1 irq_en, bits[7:4] opcode.
REQ-016 SHALL define the status word as regs_to_proc[0]: bit0 busy, bit1 done, bit2 err, bit3 timeout, bits[7:4] state encoding; all other bits 0.
REQ-017 SHALL drive regs_to_proc[1..6] with the latched results and regs_to_proc[7] with the busy-cycle count, zero-extended.
REQ-018 SHALL implement the FSM states IDLE, REQ, BUSY, DONE.
REQ-019 SHALL detect start on the 0->1 edge of regs_from_proc[0][0] (registered previous value), seen only in IDLE; in IDLE it latches opcode, irq_en and params[1..6], clears done/err/timeout and the counter, and moves to REQ.
REQ-020 SHALL, in REQ, hold acc_req=1 with stable acc_op/acc_param until acc_ack=1, then move to BUSY with acc_req=0 next cycle.
REQ-021 SHALL treat acc_ack and acc_done in the same cycle in REQ as acceptance plus completion, going directly to DONE.
REQ-022 SHALL, in BUSY, increment the counter each cycle, saturating at all-ones.
REQ-023 SHALL, on acc_done in BUSY, latch acc_result into the result registers, set err=acc_err and done=1, and move to DONE.
REQ-024 SHALL, when the counter reaches TIMEOUT_CYCLES-1 in BUSY without acc_done, set timeout=1, err=1, done=1, keep the result registers, and move to DONE; acc_done in that same cycle takes priority.
REQ-025 SHALL assert ext_irq for exactly one cycle on entry to DONE when the latched irq_en=1.
REQ-026 SHALL hold DONE until regs_from_proc[0][0]==0, then return to IDLE while keeping the done/err/timeout bits and results visible.
REQ-027 SHALL set busy=1 in REQ and BUSY only.
REQ-028 SHALL ignore start edges outside IDLE; a held start bit never retriggers.
REQ-029 SHALL ignore acc_done outside REQ and BUSY.
REQ-030 SHALL drive acc_param from the latched copy only; later processor writes do not affect an in-flight job.

Reset
REQ-031 SHALL, on rst=1, asynchronously set state to IDLE and clear to 0: acc_req, ext_irq, the status bits, all result registers, the counter, latched params/op and the previous-start register.
REQ-032 SHALL, when rst is asserted mid-job, abandon the job; the accelerator is reset by the same rst.
REQ-033 SHALL ignore a start bit that is already 1 at reset release; only a subsequent 0->1 edge starts a job.

Structure
REQ-034 SHALL place the state enum, status bit-index constants, command field positions and the register count (8) in a shared package, accel_mailbox_pkg.
REQ-035 SHALL use one sub-module, mailbox_timeout_ctr: the saturating counter with its clear/enable inputs and timeout compare.
REQ-036 SHALL be instantiated at the top level next to proc, with regs_to_proc wired to proc's register_accelerator_in and ext_irq wired to EXT.

Verification
REQ-037 Basic job: op=3, irq_en=1, start 0->1; ack 2 cycles later; done 10 cycles after ack with results 1..6 -> status done=1, err=0, results 1..6 readable, regs_to_proc[7]=10, one-cycle ext_irq pulse.
REQ-038 Timeout: TIMEOUT_CYCLES=16, acc_done never asserted -> after 16 BUSY cycles status timeout=1, err=1, done=1, busy=0.
REQ-039 Held start: start kept at 1 through DONE -> no second acc_req; clear start, set it again -> a new job runs and done is cleared during REQ.
REQ-040 Same-cycle ack and done in REQ -> DONE the next cycle, results latched, regs_to_proc[7]=0.
REQ-041 Mid-job reset: rst pulsed during BUSY -> all outputs 0 immediately, state IDLE, no ext_irq.
REQ-042 irq_en=0 with acc_err=1 at done -> err=1, done=1, ext_irq never asserted.
